count_game_top: RTL and testbench

Top level of the counting game: the player sets a target (0–99) on the switches, starts a round with `start`, and stops it with a second `start` press. A hit occurs when the running count equals the target at the stop. The block drives the 8-digit 7-segment display, the 8×8 red/green dot matrix, a 16-LED hit history and the buzzer. It is the FPGA top: all board I/O terminates here.

---
 rtl/count_game_pkg.sv | 64 ++++++
 rtl/count_game_top_debounce.sv | 52 +++++
 rtl/count_game_top.sv | 184 ++++++++++++++++++
 tb/tb_count_game_top.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_game_pkg.sv
// Shared types, constants and helpers for the counting game.
package count_game_pkg;

  localparam int unsigned COUNT_DIV_DEF = 100;
  localparam int unsigned DEBOUNCE_DEF  = 4;
  localparam int unsigned SCAN_DIV_DEF  = 8;
  localparam int unsigned BEEP_LEN_DEF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESULT
  } state_e;

  // Two-digit BCD value, tens in hi.
  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } bcd2_t;

  localparam logic [7:0] HIT_EDGE_ROW = 8'hFF;
  localparam logic [7:0] HIT_SIDE_ROW = 8'h81;

  // Common-cathode {g,f,e,d,c,b,a} patterns; non-decimal codes stay dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Increment modulo 100.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.lo == 4'd9) begin
      r.lo = 4'd0;
      r.hi = (v.hi == 4'd9) ? 4'd0 : v.hi + 4'd1;
    end else begin
      r.lo = v.lo + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] hit_row(input logic [2:0] r);
    return (r == 3'd0 || r == 3'd7) ? HIT_EDGE_ROW : HIT_SIDE_ROW;
  endfunction

  function automatic logic [7:0] miss_row(input logic [2:0] r);
    return (8'h01 << r) | (8'h80 >> r);
  endfunction

endpackage

// File: rtl/count_game_top_debounce.sv
// Start button conditioning: 2-FF synchroniser, stability counter and
// single-cycle press pulse per held press.
module debounce_edge #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fired_q, fired_d;
  logic          at_len;

  assign at_len = (cnt_q == CW'(DEBOUNCE - 1));

  // Synchroniser and stability state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  // Count stable-high cycles; pulse once, re-arm only after a low cycle.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    press_o = 1'b0;
    if (!sync2_q) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (!at_len) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      press_o = !fired_q;
      fired_d = 1'b1;
    end
  end

endmodule

// File: rtl/count_game_top.sv
// Counting game FPGA top: round FSM, BCD counters, beep timer and the
// scanned 7-segment / dot-matrix drivers.
module count_game_top
  import count_game_pkg::*;
#(
  parameter int unsigned COUNT_DIV = COUNT_DIV_DEF,
  parameter int unsigned DEBOUNCE  = DEBOUNCE_DEF,
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
  parameter int unsigned BEEP_LEN  = BEEP_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  sw,
  output logic [15:0] led,
  output logic [7:0]  seg,
  output logic [7:0]  dig,
  output logic [7:0]  row,
  output logic [7:0]  colg,
  output logic [7:0]  colr,
  output logic        beep
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = $clog2(BEEP_LEN + 1);

  logic          press;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  bcd2_t         count_q, count_d, round_q, round_d, score_q, score_d;
  bcd2_t         count_next, tgt;
  logic [15:0]   led_q, led_d;
  logic          hit_q, hit_d, hit_now, wrap;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;
  logic [SW-1:0] scan_div_q;
  logic [2:0]    scan_idx_q;
  logic [7:0]    seg_q, seg_d, dig_q, dig_d, row_q, row_d;
  logic [7:0]    colg_q, colg_d, colr_q, colr_d;
  logic [6:0]    tgt_bin;
  logic [3:0]    nib;

  debounce_edge #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk_i   (clk),
    .rst_ni  (rst),
    .din_i   (start),
    .press_o (press)
  );

  assign tgt_bin    = (sw > 7'd99) ? 7'd99 : sw;
  assign tgt.hi     = 4'(tgt_bin / 7'd10);
  assign tgt.lo     = 4'(tgt_bin % 7'd10);
  assign wrap       = (presc_q == PW'(COUNT_DIV - 1));
  // A stop in the wrap cycle must see the incremented count.
  assign count_next = wrap ? bcd_inc(count_q) : count_q;
  assign hit_now    = (count_next == tgt);

  // Game state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      count_q    <= '0;
      round_q    <= '0;
      score_q    <= '0;
      led_q      <= '0;
      hit_q      <= 1'b0;
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      round_q    <= round_d;
      score_q    <= score_d;
      led_q      <= led_d;
      hit_q      <= hit_d;
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
    end
  end

  // Round FSM, counters and beep timer.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    round_d    = round_q;
    score_d    = score_q;
    led_d      = led_q;
    hit_d      = hit_q;
    beep_cnt_d = '0;
    beep_d     = 1'b0;
    if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
      beep_d     = 1'b1;
    end
    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (press) begin
          state_d    = ST_RUN;
          presc_d    = '0;
          count_d    = '0;
          round_d    = bcd_inc(round_q);
          beep_cnt_d = '0;
          beep_d     = 1'b0;
        end
      end
      ST_RUN: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        count_d = count_next;
        if (press) begin
          state_d = ST_RESULT;
          hit_d   = hit_now;
          led_d   = {led_q[14:0], hit_now};
          if (hit_now) begin
            if (score_q != 8'h99) score_d = bcd_inc(score_q);
            beep_cnt_d = BW'(BEEP_LEN - 1);
            beep_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit and matrix-row content for the current scan index.
  always_comb begin
    case (scan_idx_q)
      3'd7:    nib = tgt.hi;
      3'd6:    nib = tgt.lo;
      3'd5:    nib = count_q.hi;
      3'd4:    nib = count_q.lo;
      3'd3:    nib = round_q.hi;
      3'd2:    nib = round_q.lo;
      3'd1:    nib = score_q.hi;
      default: nib = score_q.lo;
    endcase
    seg_d  = {1'b0, seg7(nib)};
    dig_d  = ~(8'h01 << scan_idx_q);
    row_d  = ~(8'h01 << scan_idx_q);
    colg_d = '0;
    colr_d = '0;
    if (state_q == ST_RESULT) begin
      if (hit_q) colg_d = hit_row(scan_idx_q);
      else       colr_d = miss_row(scan_idx_q);
    end
  end

  // Scan timing and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_div_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= '0;
      dig_q      <= '1;
      row_q      <= '1;
      colg_q     <= '0;
      colr_q     <= '0;
    end else begin
      if (scan_div_q == SW'(SCAN_DIV - 1)) begin
        scan_div_q <= '0;
        scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
        scan_div_q <= scan_div_q + 1'b1;
      end
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      row_q  <= row_d;
      colg_q <= colg_d;
      colr_q <= colr_d;
    end
  end

  assign led  = led_q;
  assign seg  = seg_q;
  assign dig  = dig_q;
  assign row  = row_q;
  assign colg = colg_q;
  assign colr = colr_q;
  assign beep = beep_q;

endmodule

// File: tb/tb_count_game_top.sv
// Directed bench for count_game_top: table of rounds plus hand-written
// reset, scan, glitch, long-hold and mid-round reset sequences.
module tb_count_game_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  sw = 7'd0;
  logic [15:0] led;
  logic [7:0]  seg, dig, row, colg, colr;
  logic        beep;

  always #5 clk = ~clk;

  count_game_top #(
    .COUNT_DIV (100),
    .DEBOUNCE  (4),
    .SCAN_DIV  (8),
    .BEEP_LEN  (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sw    (sw),
    .led   (led),
    .seg   (seg),
    .dig   (dig),
    .row   (row),
    .colg  (colg),
    .colr  (colr),
    .beep  (beep)
  );

  typedef struct {
    int sw;
    int run;
    int cnt;
    bit hit;
  } vec_t;

  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  seg_cap[8], g_cap[8], r_cap[8];
  int          m_score = 0, m_round = 0;
  logic [15:0] m_led = '0;

  function automatic int seg2dig(input logic [7:0] s);
    case (s)
      8'h3F: return 0;
      8'h06: return 1;
      8'h5B: return 2;
      8'h4F: return 3;
      8'h66: return 4;
      8'h6D: return 5;
      8'h7D: return 6;
      8'h07: return 7;
      8'h7F: return 8;
      8'h6F: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Collect one full scan frame, bounded in cycles.
  task automatic capture();
    bit         got[8];
    int         n = 0;
    int         rowbad = 0;
    logic [7:0] sel;
    for (int i = 0; i < 8; i++) got[i] = 1'b0;
    for (int c = 0; c < 300 && n < 8; c++) begin
      @(negedge clk);
      if (row != dig) rowbad++;
      for (int i = 0; i < 8; i++) begin
        sel = 8'h01 << i;
        if (dig == ~sel && !got[i]) begin
          got[i]     = 1'b1;
          seg_cap[i] = seg;
          g_cap[i]   = colg;
          r_cap[i]   = colr;
          n++;
        end
      end
    end
    chk("scan frame digits", n, 8);
    chk("row follows dig", rowbad, 0);
  endtask

  task automatic show_num(input string name, input int hi, input int exp);
    int a, b, act;
    a = seg2dig(seg_cap[hi]);
    b = seg2dig(seg_cap[hi-1]);
    act = (a < 0 || b < 0) ? -1 : a * 10 + b;
    chk(name, act, exp);
  endtask

  // mat: 0 blank, 1 green border, 2 red X. A negative cnt skips the count.
  task automatic check_display(input int tgt, input int cnt, input int rnd,
                               input int scr, input int mat);
    int         nbad = 0;
    logic [7:0] eg, er;
    capture();
    show_num("target digits", 7, tgt);
    if (cnt >= 0) show_num("count digits", 5, cnt);
    show_num("round digits", 3, rnd);
    show_num("score digits", 1, scr);
    for (int r = 0; r < 8; r++) begin
      eg = 8'h00;
      er = 8'h00;
      if (mat == 1) eg = (r == 0 || r == 7) ? 8'hFF : 8'h81;
      if (mat == 2) er = (8'h80 >> r) | (8'h01 << r);
      if (g_cap[r] !== eg || r_cap[r] !== er) nbad++;
    end
    chk("matrix rows wrong", nbad, 0);
  endtask

  // Rising edge of start, then n cycles until the next rising edge.
  task automatic press_and_wait(input int n);
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b0;
    end
  endtask

  // Stop press; measures how long beep stays high after the state change.
  task automatic stop_round(output int blen);
    blen  = 0;
    start = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b0;
      if (i >= 6 && beep === 1'b1) blen++;
    end
  endtask

  initial begin
    int fe, blen, tgt;

    vecs[0] = '{43, 4350, 43, 1'b1};
    vecs[1] = '{43, 2500, 25, 1'b0};
    vecs[2] = '{10, 1050, 10, 1'b1};
    vecs[3] = '{0, 99, 0, 1'b1};
    vecs[4] = '{1, 100, 1, 1'b1};
    vecs[5] = '{120, 9950, 99, 1'b1};
    vecs[6] = '{120, 10050, 0, 1'b0};
    vecs[7] = '{5, 600, 6, 1'b0};

    // Reset values.
    sw  = 7'd43;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset led", int'(led), 0);
    chk("reset seg", int'(seg), 0);
    chk("reset dig", int'(dig), 8'hFF);
    chk("reset row", int'(row), 8'hFF);
    chk("reset colg|colr", int'({colg, colr}), 0);
    chk("reset beep", int'(beep), 0);

    // Scan step after release.
    rst = 1'b1;
    fe  = 0;
    @(negedge clk);
    while (dig == 8'hFE && fe < 50) begin
      fe++;
      @(negedge clk);
    end
    chk("cycles on digit 0", fe, 8);
    chk("second digit select", int'(dig), 8'hFD);
    check_display(43, 0, 0, 0, 0);

    // Table of rounds.
    for (int v = 0; v < 8; v++) begin
      sw = 7'(vecs[v].sw);
      press_and_wait(vecs[v].run);
      stop_round(blen);
      m_round = (m_round + 1) % 100;
      if (vecs[v].hit && m_score < 99) m_score++;
      m_led = {m_led[14:0], vecs[v].hit};
      tgt   = (vecs[v].sw > 99) ? 99 : vecs[v].sw;
      chk($sformatf("round%0d led", v), int'(led), int'(m_led));
      chk($sformatf("round%0d beep length", v), blen, vecs[v].hit ? 64 : 0);
      check_display(tgt, vecs[v].cnt, m_round, m_score, vecs[v].hit ? 1 : 2);
    end

    // Two-cycle glitch: stays in RESULT.
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check_display(5, 6, m_round, m_score, 2);

    // Long hold: exactly one press, into RUN.
    start = 1'b1;
    repeat (1000) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    m_round = (m_round + 1) % 100;
    check_display(5, -1, m_round, m_score, 0);
    chk("led during run", int'(led), int'(m_led));

    // Reset mid-round.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("led after reset", int'(led), 0);
    check_display(5, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
